// File: rtl/aula_pio_pkg.sv
// Shared constants and helpers for the PIO input conditioning path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   PIO_IN_WIDTH            - width of the PIO in_port
//   DEBOUNCE_CYCLES_DEFAULT - stable cycles required (1 ms at 50 MHz)
//   db_cnt_width()          - counter width needed to hold 0..cycles
package aula_pio_pkg;

    localparam int PIO_IN_WIDTH            = 8;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

    function automatic int db_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/aula_pio_in_debounce_bit.sv
// One-bit synchroniser + debouncer with registered rise/fall pulses.
// Latency: new level appears on o_db DEBOUNCE_CYCLES+1 edges after sync0 first samples it.
// Backpressure: none; free-running, input is sampled every cycle.
//
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   i_raw       - asynchronous input bit
//   o_db        - debounced level (registered)
//   o_rise      - one-cycle pulse on o_db 0->1 (registered)
//   o_fall      - one-cycle pulse on o_db 1->0 (registered)
//   o_accept    - combinational: a change is accepted on the coming edge
module debounce_bit
    import aula_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_db,
    output logic o_rise,
    output logic o_fall,
    output logic o_accept
);

    localparam int              CW   = db_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync0;
    logic          r_sync1;
    logic          r_db;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_cnt;
    logic          w_accept;

    // The last counted cycle: the new level is committed on this edge.
    assign w_accept = (r_sync1 != r_db) && (r_cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_db    <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync0 <= i_raw;
            r_sync1 <= r_sync0;
            r_rise  <= w_accept &  r_sync1;
            r_fall  <= w_accept & ~r_sync1;
            if (r_sync1 == r_db) begin
                // Input agrees with the output: any partial count was a glitch.
                r_cnt <= '0;
            end else if (w_accept) begin
                r_db  <= r_sync1;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_db     = r_db;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_accept = w_accept;

endmodule

// File: rtl/aula_pio_in_debounce.sv
// Board-pin conditioning for the PIO input port: per-bit sync, debounce and edge pulses.
// Latency: 2-flop sync plus DEBOUNCE_CYCLES stable cycles; pulses coincide with the db_out change.
// Backpressure: none; every bit is processed every cycle in parallel.
//
// Ports:
//   clk, reset  - system clock (PIO domain), asynchronous active-high reset
//   raw_in      - asynchronous board switches/keys
//   db_out      - debounced levels, feeds PIO in_port
//   rise_pulse  - per-bit one-cycle pulse on db_out 0->1
//   fall_pulse  - per-bit one-cycle pulse on db_out 1->0
//   any_change  - registered OR of all rise/fall pulses, aligned with them
//
// Build option: define PIO_IN_DB_INVERT_EN to invert raw_in ahead of the
// synchroniser for active-low keys; reset values are the same either way.
module aula_pio_in_debounce
    import aula_pio_pkg::*;
#(
    parameter int WIDTH           = PIO_IN_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_accept;
    logic             r_any_change;

`ifdef PIO_IN_DB_INVERT_EN
    // Idle-high keys become 0, matching the all-zero synchroniser reset,
    // so no pulse is produced as the chain fills after reset.
    assign w_raw = ~raw_in;
`else
    assign w_raw = raw_in;
`endif

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .reset    (reset),
            .i_raw    (w_raw[g]),
            .o_db     (db_out[g]),
            .o_rise   (rise_pulse[g]),
            .o_fall   (fall_pulse[g]),
            .o_accept (w_accept[g])
        );
    end

    // Registered from the same accept terms that load the pulse flops,
    // so any_change lines up exactly with rise_pulse/fall_pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_any_change <= 1'b0;
        end else begin
            r_any_change <= |w_accept;
        end
    end

    assign any_change = r_any_change;

endmodule

// File: tb/tb_aula_pio_in_debounce.sv
// Self-checking bench for aula_pio_in_debounce with DEBOUNCE_CYCLES=4.
// Reference model: a bit's output takes a new value once the last DC sampled
// input values (as seen two edges later through the synchroniser) all agree on it.
module tb_aula_pio_in_debounce;

    localparam int W  = 8;
    localparam int DC = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] raw_in;
    logic [W-1:0] db_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
    logic         any_change;

    int checks   = 0;
    int failures = 0;

    aula_pio_in_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .db_out     (db_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .any_change (any_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // m_hist[0] is the input sampled on the previous edge, m_hist[i] i edges earlier.
    logic [W-1:0] m_hist [0:DC];
    logic [W-1:0] m_db, m_rise, m_fall;
    logic         m_any;
    logic [W-1:0] m_all1, m_all0, m_nxt, m_smp;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= DC; i++) m_hist[i] = '0;
            m_db = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
        end else begin
            m_all1 = '1;
            m_all0 = '1;
            for (int i = 1; i <= DC; i++) begin
                m_all1 = m_all1 &  m_hist[i];
                m_all0 = m_all0 & ~m_hist[i];
            end
            m_nxt  = (m_db & ~m_all0) | (~m_db & m_all1);
            m_rise = ~m_db & m_nxt;
            m_fall = m_db & ~m_nxt;
            m_any  = |(m_rise | m_fall);
            m_db   = m_nxt;
`ifdef PIO_IN_DB_INVERT_EN
            m_smp = ~raw_in;
`else
            m_smp = raw_in;
`endif
            for (int i = DC; i >= 1; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = m_smp;
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        raw_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({db_out, rise_pulse, fall_pulse, any_change} !== {(3*W+1){1'b0}}) begin
            failures++;
            $display("FAIL reset_initial got db=%h r=%h f=%h a=%b want all 0", db_out, rise_pulse, fall_pulse, any_change);
        end
        reset  = 1'b0;
        raw_in = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if ({db_out, rise_pulse, fall_pulse, any_change} !== {m_db, m_rise, m_fall, m_any}) begin
                failures++;
                $display("FAIL reset_fill k=%0d got db=%h r=%h f=%h a=%b want db=%h r=%h f=%h a=%b", k, db_out, rise_pulse, fall_pulse, any_change, m_db, m_rise, m_fall, m_any);
            end
        end
        checks++;
        if (db_out !== 8'hFF) begin
            failures++;
            $display("FAIL reset_preload got db=%h want ff", db_out);
        end
        // Assert mid-cycle: outputs must clear without waiting for a clock edge.
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({db_out, rise_pulse, fall_pulse, any_change} !== {(3*W+1){1'b0}}) begin
            failures++;
            $display("FAIL reset_async got db=%h r=%h f=%h a=%b want all 0", db_out, rise_pulse, fall_pulse, any_change);
        end
        raw_in = 8'h00;
        @(posedge clk);
        #4 reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if ({db_out, rise_pulse, fall_pulse, any_change} !== {(3*W+1){1'b0}}) begin
                failures++;
                $display("FAIL reset_release k=%0d got db=%h r=%h f=%h a=%b want all 0", k, db_out, rise_pulse, fall_pulse, any_change);
            end
        end
    endtask

    // Apply val (already at posedge+1), then check the fixed latency/pulse
    // expectations against constants and the model for 10 edges.
    task automatic test_step(input string name, input logic [W-1:0] from, input logic [W-1:0] val);
        logic [W-1:0] e_db, e_r, e_f;
        raw_in = val;
        for (int k = 0; k < 10; k++) begin
            tick();
            e_db = (k >= DC + 1) ? val : from;
            e_r  = (k == DC + 1) ? (val & ~from) : '0;
            e_f  = (k == DC + 1) ? (from & ~val) : '0;
            checks++;
            if ({db_out, rise_pulse, fall_pulse, any_change} !== {e_db, e_r, e_f, |(e_r | e_f)}) begin
                failures++;
                $display("FAIL %s k=%0d got db=%h r=%h f=%h a=%b want db=%h r=%h f=%h a=%b", name, k, db_out, rise_pulse, fall_pulse, any_change, e_db, e_r, e_f, |(e_r | e_f));
            end
            checks++;
            if ({db_out, rise_pulse, fall_pulse, any_change} !== {m_db, m_rise, m_fall, m_any}) begin
                failures++;
                $display("FAIL %s_model k=%0d got db=%h r=%h f=%h a=%b want db=%h r=%h f=%h a=%b", name, k, db_out, rise_pulse, fall_pulse, any_change, m_db, m_rise, m_fall, m_any);
            end
        end
    endtask

    task automatic test_clean_step();
        test_step("clean_rise", 8'h00, 8'h01);
        test_step("clean_fall", 8'h01, 8'h00);
    endtask

    task automatic test_glitch();
        raw_in = 8'h08;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 2) raw_in = 8'h00;
            checks++;
            if ({db_out, rise_pulse, fall_pulse, any_change} !== {(3*W+1){1'b0}}) begin
                failures++;
                $display("FAIL glitch k=%0d got db=%h r=%h f=%h a=%b want all 0", k, db_out, rise_pulse, fall_pulse, any_change);
            end
        end
    endtask

    task automatic test_simultaneous();
        test_step("multi_rise", 8'h00, 8'hA5);
        test_step("multi_fall", 8'hA5, 8'h00);
    endtask

    task automatic test_reset_midcount();
        raw_in = 8'h80;
        repeat (3) tick();
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({db_out, rise_pulse, fall_pulse, any_change} !== {(3*W+1){1'b0}}) begin
            failures++;
            $display("FAIL midcount_reset got db=%h r=%h f=%h a=%b want all 0", db_out, rise_pulse, fall_pulse, any_change);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({db_out, rise_pulse, fall_pulse, any_change} !== {(3*W+1){1'b0}}) begin
            failures++;
            $display("FAIL midcount_hold got db=%h r=%h f=%h a=%b want all 0", db_out, rise_pulse, fall_pulse, any_change);
        end
        #3 reset = 1'b0;
        test_step("midcount_restart", 8'h00, 8'h80);
        test_step("midcount_clear", 8'h80, 8'h00);
    endtask

    task automatic test_back_to_back_random();
        logic [W-1:0] v;
        int           hold;
        for (int s = 0; s < 200; s++) begin
            v    = W'($urandom);
            hold = $urandom_range(1, 2 * DC);
            raw_in = v;
            for (int h = 0; h < hold; h++) begin
                tick();
                checks++;
                if ({db_out, rise_pulse, fall_pulse, any_change} !== {m_db, m_rise, m_fall, m_any}) begin
                    failures++;
                    $display("FAIL random s=%0d h=%0d got db=%h r=%h f=%h a=%b want db=%h r=%h f=%h a=%b", s, h, db_out, rise_pulse, fall_pulse, any_change, m_db, m_rise, m_fall, m_any);
                end
                checks++;
                if ((rise_pulse & fall_pulse) !== '0) begin
                    failures++;
                    $display("FAIL random_both s=%0d got r=%h f=%h want no overlap", s, rise_pulse, fall_pulse);
                end
            end
        end
    endtask

    task automatic test_invert();
        reset  = 1'b1;
        raw_in = 8'hFF;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if ({db_out, rise_pulse, fall_pulse, any_change} !== {(3*W+1){1'b0}}) begin
                failures++;
                $display("FAIL invert_idle k=%0d got db=%h r=%h f=%h a=%b want all 0", k, db_out, rise_pulse, fall_pulse, any_change);
            end
        end
        raw_in = 8'hFE;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if ({db_out, rise_pulse, any_change} !== {((k >= DC + 1) ? 8'h01 : 8'h00), ((k == DC + 1) ? 8'h01 : 8'h00), (k == DC + 1)}) begin
                failures++;
                $display("FAIL invert_press k=%0d got db=%h r=%h a=%b", k, db_out, rise_pulse, any_change);
            end
        end
        raw_in = 8'hFF;
        repeat (10) tick();
    endtask

    initial begin
        reset  = 1'b1;
        raw_in = '0;
`ifdef PIO_IN_DB_INVERT_EN
        test_invert();
`else
        test_reset();
        test_clean_step();
        test_glitch();
        test_simultaneous();
        test_reset_midcount();
`endif
        test_back_to_back_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
